// File: rtl/reservation_station_pkg.sv
// Shared definitions for the reservation station: opcode enumeration, RoB tag
// width, the "operand present" tag, the per-entry record and the memory-op test.
// No logic of its own; imported by the station top and its select sub-module.
package reservation_station_pkg;

    localparam int TAG_W = 5;

    // Bit 4 set marks an operand whose value is already captured.
    localparam logic [TAG_W-1:0] READY_TAG = 5'b10000;

    typedef enum logic [5:0] {
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU, SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
    } opcode_t;

    typedef struct packed {
        logic [5:0]       inst_type;
        logic [TAG_W-1:0] q1;
        logic [TAG_W-1:0] q2;
        logic [31:0]      v1;
        logic [31:0]      v2;
        logic [31:0]      imm;
        logic [31:0]      pc;
        logic [TAG_W-1:0] dest;
    } rs_entry_t;

    // Loads and stores are owned by the load/store buffer.
    function automatic logic is_mem(input logic [5:0] t);
        return (t >= 6'(LB)) && (t <= 6'(SW));
    endfunction

endpackage

// File: rtl/reservation_station_rs_select.sv
// Two lowest-index priority encoders: first free slot and first ready slot.
// Purely combinational, zero latency; no flow control of its own.
// Ports: free_vec/ready_vec in, *_idx and *_found out per encoder.
module rs_select #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  free_vec,
    input  logic [N-1:0]  ready_vec,
    output logic [IW-1:0] free_idx,
    output logic          free_found,
    output logic [IW-1:0] ready_idx,
    output logic          ready_found
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                free_idx   = IW'(i);
                free_found = 1'b1;
            end
        end
    end

    always_comb begin
        ready_idx   = '0;
        ready_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                ready_idx   = IW'(i);
                ready_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Out-of-order issue buffer: holds renamed ALU ops until both operands arrive,
// snoops ALU/load broadcasts, issues the lowest ready entry one cycle after it becomes ready.
// Backpressure: rs_full asserts with one free slot left to absorb the RoB's late dispatch.
// Ports: clk_in/rst_in/rdy_in/rob_clear control; rs_* dispatch in; alu_*/load_* broadcasts in;
// rs_full and registered alu_* issue port out. Optional macro: RS_BYPASS_EN (dispatch-cycle
// capture of a same-cycle broadcast).
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int ENTRIES = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic        rs_todo,
    input  logic [5:0]  rs_inst_type,
    input  logic [4:0]  rs_rs1_rob_pos,
    input  logic [4:0]  rs_rs2_rob_pos,
    input  logic [31:0] rs_val1,
    input  logic [31:0] rs_val2,
    input  logic [31:0] rs_imm,
    input  logic [31:0] rs_pc,
    input  logic [4:0]  rs_rd_rob_pos,
    input  logic        alu_done,
    input  logic [31:0] alu_res,
    input  logic [4:0]  alu_rob_pos,
    input  logic        load_done,
    input  logic [31:0] load_res,
    input  logic [4:0]  load_rob_pos,
    output logic        rs_full,
    output logic        alu_todo,
    output logic [5:0]  alu_inst_type,
    output logic [31:0] alu_val1,
    output logic [31:0] alu_val2,
    output logic [31:0] alu_imm,
    output logic [31:0] alu_pc,
    output logic [4:0]  alu_rd_rob_pos
);

    localparam int IW = $clog2(ENTRIES);
    localparam logic [IW:0] FULL_AT = (IW + 1)'(ENTRIES - 1);

    logic [ENTRIES-1:0] busy;
    rs_entry_t          ent [ENTRIES];

    logic [ENTRIES-1:0] free_vec;
    logic [ENTRIES-1:0] ready_vec;
    logic [IW-1:0]      free_idx;
    logic [IW-1:0]      ready_idx;
    logic               free_found;
    logic               ready_found;
    logic [IW:0]        busy_cnt;

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            free_vec[i]  = !busy[i];
            ready_vec[i] = busy[i] && ent[i].q1[4] && ent[i].q2[4];
        end
    end

    rs_select #(.N(ENTRIES), .IW(IW)) u_select (
        .free_vec   (free_vec),
        .ready_vec  (ready_vec),
        .free_idx   (free_idx),
        .free_found (free_found),
        .ready_idx  (ready_idx),
        .ready_found(ready_found)
    );

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            busy_cnt = busy_cnt + {{IW{1'b0}}, busy[i]};
        end
    end

    assign rs_full = (busy_cnt >= FULL_AT);

    // Incoming operands; with bypass enabled a same-cycle broadcast is captured
    // here because the wakeup snoop only looks at entries already resident.
    logic [4:0]  in_q1, in_q2;
    logic [31:0] in_v1, in_v2;

    always_comb begin
        in_q1 = rs_rs1_rob_pos;
        in_v1 = rs_val1;
        in_q2 = rs_rs2_rob_pos;
        in_v2 = rs_val2;
`ifdef RS_BYPASS_EN
        if (!in_q1[4]) begin
            if (alu_done && in_q1 == alu_rob_pos) begin
                in_q1 = READY_TAG;
                in_v1 = alu_res;
            end else if (load_done && in_q1 == load_rob_pos) begin
                in_q1 = READY_TAG;
                in_v1 = load_res;
            end
        end
        if (!in_q2[4]) begin
            if (alu_done && in_q2 == alu_rob_pos) begin
                in_q2 = READY_TAG;
                in_v2 = alu_res;
            end else if (load_done && in_q2 == load_rob_pos) begin
                in_q2 = READY_TAG;
                in_v2 = load_res;
            end
        end
`endif
    end

    // Wakeup touches busy entries, issue clears a busy entry and dispatch fills a
    // free one, so the three updates never target the same slot in one cycle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy           <= '0;
            alu_todo       <= 1'b0;
            alu_inst_type  <= '0;
            alu_val1       <= '0;
            alu_val2       <= '0;
            alu_imm        <= '0;
            alu_pc         <= '0;
            alu_rd_rob_pos <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ent[i] <= '0;
            end
        end else if (!rdy_in) begin
            alu_todo <= 1'b0;
        end else if (rob_clear) begin
            busy     <= '0;
            alu_todo <= 1'b0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (busy[i]) begin
                    if (!ent[i].q1[4]) begin
                        if (alu_done && ent[i].q1 == alu_rob_pos) begin
                            ent[i].q1 <= READY_TAG;
                            ent[i].v1 <= alu_res;
                        end else if (load_done && ent[i].q1 == load_rob_pos) begin
                            ent[i].q1 <= READY_TAG;
                            ent[i].v1 <= load_res;
                        end
                    end
                    if (!ent[i].q2[4]) begin
                        if (alu_done && ent[i].q2 == alu_rob_pos) begin
                            ent[i].q2 <= READY_TAG;
                            ent[i].v2 <= alu_res;
                        end else if (load_done && ent[i].q2 == load_rob_pos) begin
                            ent[i].q2 <= READY_TAG;
                            ent[i].v2 <= load_res;
                        end
                    end
                end
            end

            alu_todo <= ready_found;
            if (ready_found) begin
                busy[ready_idx] <= 1'b0;
                alu_inst_type   <= ent[ready_idx].inst_type;
                alu_val1        <= ent[ready_idx].v1;
                alu_val2        <= ent[ready_idx].v2;
                alu_imm         <= ent[ready_idx].imm;
                alu_pc          <= ent[ready_idx].pc;
                alu_rd_rob_pos  <= ent[ready_idx].dest;
            end

            if (rs_todo && !is_mem(rs_inst_type) && free_found) begin
                busy[free_idx] <= 1'b1;
                ent[free_idx]  <= '{inst_type: rs_inst_type, q1: in_q1, q2: in_q2,
                                   v1: in_v1, v2: in_v2, imm: rs_imm, pc: rs_pc,
                                   dest: rs_rd_rob_pos};
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station with a scoreboard of expected issues.
// Stimulus is driven on the falling edge; the monitor samples 1 time unit after each rising edge.
// Build with or without RS_BYPASS_EN; the dispatch-cycle broadcast test adapts.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, rob_clear, rs_todo;
    logic [5:0]  rs_inst_type;
    logic [4:0]  rs_rs1_rob_pos, rs_rs2_rob_pos, rs_rd_rob_pos;
    logic [31:0] rs_val1, rs_val2, rs_imm, rs_pc;
    logic        alu_done, load_done;
    logic [31:0] alu_res, load_res;
    logic [4:0]  alu_rob_pos, load_rob_pos;
    logic        rs_full, alu_todo;
    logic [5:0]  alu_inst_type;
    logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
    logic [4:0]  alu_rd_rob_pos;

    typedef struct {
        logic [5:0]  t;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    int   tests       = 0;
    int   fails       = 0;
    int   issue_count = 0;

    always #5 clk_in = ~clk_in;

    reservation_station #(.ENTRIES(8)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .rob_clear     (rob_clear),
        .rs_todo       (rs_todo),
        .rs_inst_type  (rs_inst_type),
        .rs_rs1_rob_pos(rs_rs1_rob_pos),
        .rs_rs2_rob_pos(rs_rs2_rob_pos),
        .rs_val1       (rs_val1),
        .rs_val2       (rs_val2),
        .rs_imm        (rs_imm),
        .rs_pc         (rs_pc),
        .rs_rd_rob_pos (rs_rd_rob_pos),
        .alu_done      (alu_done),
        .alu_res       (alu_res),
        .alu_rob_pos   (alu_rob_pos),
        .load_done     (load_done),
        .load_res      (load_res),
        .load_rob_pos  (load_rob_pos),
        .rs_full       (rs_full),
        .alu_todo      (alu_todo),
        .alu_inst_type (alu_inst_type),
        .alu_val1      (alu_val1),
        .alu_val2      (alu_val2),
        .alu_imm       (alu_imm),
        .alu_pc        (alu_pc),
        .alu_rd_rob_pos(alu_rd_rob_pos)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic dispatch(input logic [5:0] t, input logic [4:0] q1, input logic [4:0] q2,
                            input logic [31:0] v1, input logic [31:0] v2,
                            input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
        rs_todo        = 1'b1;
        rs_inst_type   = t;
        rs_rs1_rob_pos = q1;
        rs_rs2_rob_pos = q2;
        rs_val1        = v1;
        rs_val2        = v2;
        rs_imm         = imm;
        rs_pc          = pc;
        rs_rd_rob_pos  = rd;
        @(negedge clk_in);
        rs_todo = 1'b0;
    endtask

    task automatic alu_bcast(input logic [4:0] tag, input logic [31:0] res);
        alu_done    = 1'b1;
        alu_rob_pos = tag;
        alu_res     = res;
        @(negedge clk_in);
        alu_done = 1'b0;
    endtask

    // Monitor: every issue pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (!rst_in && alu_todo) begin
                issue_count++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_issue: rd=%0d v1=0x%0h, expected no issue",
                             alu_rd_rob_pos, alu_val1);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_type", 32'(alu_inst_type), 32'(e.t));
                    check("issue_v1", alu_val1, e.v1);
                    check("issue_v2", alu_val2, e.v2);
                    check("issue_imm", alu_imm, e.imm);
                    check("issue_pc", alu_pc, e.pc);
                    check("issue_rd", 32'(alu_rd_rob_pos), 32'(e.rd));
                end
            end
        end
    end

    initial begin
        int base;
        rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; rs_todo = 1'b0;
        rs_inst_type = '0; rs_rs1_rob_pos = '0; rs_rs2_rob_pos = '0; rs_rd_rob_pos = '0;
        rs_val1 = '0; rs_val2 = '0; rs_imm = '0; rs_pc = '0;
        alu_done = 1'b0; alu_res = '0; alu_rob_pos = '0;
        load_done = 1'b0; load_res = '0; load_rob_pos = '0;
        repeat (2) @(negedge clk_in);

        check("rst_todo", 32'(alu_todo), 32'd0);
        check("rst_full", 32'(rs_full), 32'd0);
        check("rst_val1", alu_val1, 32'd0);
        check("rst_rd", 32'(alu_rd_rob_pos), 32'd0);
        rst_in = 1'b0;
        @(negedge clk_in);

        // Both operands present: issue on the edge after dispatch.
        exp_q.push_back('{t: ADD, v1: 32'd3, v2: 32'd4, imm: 32'd0, pc: 32'h100, rd: 5'd2});
        dispatch(ADD, READY_TAG, READY_TAG, 32'd3, 32'd4, 32'd0, 32'h100, 5'd2);
        check("t1_not_before", 32'(alu_todo), 32'd0);
        @(negedge clk_in);
        check("t1_issue", 32'(alu_todo), 32'd1);
        @(negedge clk_in);
        check("t1_pulse_end", 32'(alu_todo), 32'd0);

        // Waiting on tag 5, woken by ALU broadcast three cycles later.
        dispatch(ADDI, 5'd5, READY_TAG, 32'd0, 32'd9, 32'd7, 32'h104, 5'd3);
        repeat (2) @(negedge clk_in);
        check("t2_waiting", 32'(alu_todo), 32'd0);
        exp_q.push_back('{t: ADDI, v1: 32'h10, v2: 32'd9, imm: 32'd7, pc: 32'h104, rd: 5'd3});
        alu_bcast(5'd5, 32'h10);
        check("t2_wake_edge", 32'(alu_todo), 32'd0);
        @(negedge clk_in);
        check("t2_issue", 32'(alu_todo), 32'd1);
        @(negedge clk_in);

        // Fill 7 of 8, all waiting on tag 1; release together.
        for (int i = 0; i < 7; i++) begin
            dispatch(SUB, 5'd1, READY_TAG, 32'd0, 32'(i + 20), 32'd0, 32'(32'h200 + 4 * i), 5'(8 + i));
            if (i == 5) check("fill6_full", 32'(rs_full), 32'd0);
            if (i == 6) check("fill7_full", 32'(rs_full), 32'd1);
        end
        for (int i = 0; i < 7; i++)
            exp_q.push_back('{t: SUB, v1: 32'h55, v2: 32'(i + 20), imm: 32'd0,
                              pc: 32'(32'h200 + 4 * i), rd: 5'(8 + i)});
        base = issue_count;
        alu_bcast(5'd1, 32'h55);
        check("fill_full_at_wake", 32'(rs_full), 32'd1);
        @(negedge clk_in);
        check("fill_full_drop", 32'(rs_full), 32'd0);
        repeat (8) @(negedge clk_in);
        check("fill_issue_count", 32'(issue_count - base), 32'd7);

        // Store is not accepted.
        base = issue_count;
        dispatch(SW, READY_TAG, READY_TAG, 32'd1, 32'd2, 32'd0, 32'h300, 5'd4);
        check("sw_full", 32'(rs_full), 32'd0);
        repeat (3) @(negedge clk_in);
        check("sw_no_issue", 32'(issue_count - base), 32'd0);

        // Global enable low: dispatch ignored.
        base = issue_count;
        rdy_in = 1'b0;
        dispatch(ADD, READY_TAG, READY_TAG, 32'd1, 32'd1, 32'd0, 32'h310, 5'd5);
        @(negedge clk_in);
        rdy_in = 1'b1;
        repeat (3) @(negedge clk_in);
        check("rdy_low_no_issue", 32'(issue_count - base), 32'd0);

        // Flush with three waiters, a ready entry about to issue and a same-cycle dispatch.
        base = issue_count;
        for (int i = 0; i < 3; i++)
            dispatch(OR, 5'd7, READY_TAG, 32'd0, 32'd1, 32'd0, 32'h400, 5'(16 + i));
        dispatch(ADD, READY_TAG, READY_TAG, 32'd5, 32'd6, 32'd0, 32'h410, 5'd20);
        rob_clear = 1'b1;
        dispatch(AND, READY_TAG, READY_TAG, 32'd7, 32'd8, 32'd0, 32'h414, 5'd21);
        rob_clear = 1'b0;
        check("flush_todo", 32'(alu_todo), 32'd0);
        alu_bcast(5'd7, 32'h77);
        repeat (4) @(negedge clk_in);
        check("flush_no_issue", 32'(issue_count - base), 32'd0);

        // Dependency dispatched in the same cycle as its load broadcast.
        base = issue_count;
        load_done = 1'b1; load_rob_pos = 5'd6; load_res = 32'hAB;
`ifdef RS_BYPASS_EN
        exp_q.push_back('{t: XOR, v1: 32'hAB, v2: 32'd1, imm: 32'd0, pc: 32'h500, rd: 5'd9});
`endif
        dispatch(XOR, 5'd6, READY_TAG, 32'd0, 32'd1, 32'd0, 32'h500, 5'd9);
        load_done = 1'b0;
`ifdef RS_BYPASS_EN
        @(negedge clk_in);
        check("bypass_issue", 32'(alu_todo), 32'd1);
        repeat (2) @(negedge clk_in);
        check("bypass_count", 32'(issue_count - base), 32'd1);
`else
        repeat (3) @(negedge clk_in);
        check("nobypass_pending", 32'(issue_count - base), 32'd0);
        exp_q.push_back('{t: XOR, v1: 32'hCD, v2: 32'd1, imm: 32'd0, pc: 32'h500, rd: 5'd9});
        load_done = 1'b1; load_rob_pos = 5'd6; load_res = 32'hCD;
        @(negedge clk_in);
        load_done = 1'b0;
        repeat (2) @(negedge clk_in);
        check("nobypass_late_issue", 32'(issue_count - base), 32'd1);
`endif

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
